// File: rtl/rst_seq_ctrl.sv
// Ordered release of downstream reset domains, each gated by an acknowledge with a timeout.
// Optional lost-acknowledge monitor in DONE: define RST_SEQ_ACK_MON_EN.
module rst_seq_ctrl #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                                  clk_in,
    input  logic                                                  sys_reset_n,
    input  logic                                                  sw_rst_req,
    input  logic [NUM_STAGES-1:0]                                 stage_ack,
    output logic [NUM_STAGES-1:0]                                 stage_rst_n,
    output logic                                                  seq_done,
    output logic                                                  timeout_err,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] err_stage,
    output logic                                                  lost_ack
);

    localparam int unsigned IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int unsigned GW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int unsigned AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    // The state register acts as the last synchronizer flop.
    localparam int unsigned SW = SYNC_STAGES - 1;

    typedef enum logic [2:0] {StHold, StGap, StWaitAck, StDone, StErr} state_t;

    state_t                r_state, w_state_nxt;
    logic [SW-1:0]         r_sync;
    logic                  w_sync_rel;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic [GW-1:0]         r_gap_cnt, w_gap_nxt;
    logic [AW-1:0]         r_ack_cnt, w_ack_nxt;
    logic [NUM_STAGES-1:0] r_rst_n, w_rst_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_terr, w_terr_nxt;
    logic [IW-1:0]         r_estage, w_estage_nxt;

    always_ff @(posedge clk_in or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= (r_sync << 1) | SW'(1);
        end
    end

    assign w_sync_rel = r_sync[SW-1];

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_gap_nxt    = r_gap_cnt;
        w_ack_nxt    = r_ack_cnt;
        w_rst_nxt    = r_rst_n;
        w_done_nxt   = r_done;
        w_terr_nxt   = r_terr;
        w_estage_nxt = r_estage;

        if ((r_state != StHold) && sw_rst_req) begin
            w_state_nxt  = StGap;
            w_idx_nxt    = '0;
            w_rst_nxt    = '0;
            w_done_nxt   = 1'b0;
            w_terr_nxt   = 1'b0;
            w_estage_nxt = '0;
        end else begin
            unique case (r_state)
                StHold: begin
                    if (w_sync_rel) begin
                        w_state_nxt = StGap;
                        w_idx_nxt   = '0;
                    end
                end
                StGap: begin
                    if (r_gap_cnt == GW'(STAGE_DELAY - 1)) begin
                        w_rst_nxt[r_idx] = 1'b1;
                        w_state_nxt      = StWaitAck;
                    end else begin
                        w_gap_nxt = r_gap_cnt + GW'(1);
                    end
                end
                StWaitAck: begin
                    // An ack on the terminal count cycle takes priority over the timeout.
                    if (stage_ack[r_idx]) begin
                        if (r_idx == IW'(NUM_STAGES - 1)) begin
                            w_state_nxt = StDone;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt   = r_idx + IW'(1);
                            w_state_nxt = StGap;
                        end
                    end else if (r_ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                        w_state_nxt  = StErr;
                        w_terr_nxt   = 1'b1;
                        w_estage_nxt = r_idx;
                    end else begin
                        w_ack_nxt = r_ack_cnt + AW'(1);
                    end
                end
                StDone: begin
`ifdef RST_SEQ_ACK_MON_EN
                    for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
                        if (!stage_ack[k]) begin
                            w_estage_nxt = IW'(k);
                        end
                    end
`endif
                end
                StErr: begin
                end
                default: w_state_nxt = StHold;
            endcase
        end

        if (w_state_nxt != r_state || ((r_state != StHold) && sw_rst_req)) begin
            w_gap_nxt = '0;
            w_ack_nxt = '0;
        end
    end

    always_ff @(posedge clk_in or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state   <= StHold;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_ack_cnt <= '0;
            r_rst_n   <= '0;
            r_done    <= 1'b0;
            r_terr    <= 1'b0;
            r_estage  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_ack_cnt <= w_ack_nxt;
            r_rst_n   <= w_rst_nxt;
            r_done    <= w_done_nxt;
            r_terr    <= w_terr_nxt;
            r_estage  <= w_estage_nxt;
        end
    end

`ifdef RST_SEQ_ACK_MON_EN
    logic r_lost, w_lost_nxt;

    // Sticky; only sys_reset_n clears it.
    always_comb begin
        w_lost_nxt = r_lost | ((r_state == StDone) && !(&stage_ack));
    end

    always_ff @(posedge clk_in or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_lost <= 1'b0;
        end else begin
            r_lost <= w_lost_nxt;
        end
    end

    assign lost_ack = r_lost;
`else
    assign lost_ack = 1'b0;
`endif

    assign stage_rst_n = r_rst_n;
    assign seq_done    = r_done;
    assign timeout_err = r_terr;
    assign err_stage   = r_estage;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected output-change events are queued with the
// stimulus and compared in order against the observed output changes.
module tb_rst_seq_ctrl;

`ifdef RST_SEQ_ACK_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] rst;
        logic       done;
        logic       terr;
        logic [1:0] est;
        logic       lost;
    } out_t;

    typedef struct packed {
        int   cyc;
        out_t o;
    } ev_t;

    logic       clk_in      = 1'b0;
    logic       sys_reset_n = 1'b1;
    logic       sw_rst_req  = 1'b0;
    logic [3:0] stage_ack   = 4'b0000;
    logic [3:0] stage_rst_n;
    logic       seq_done;
    logic       timeout_err;
    logic [1:0] err_stage;
    logic       lost_ack;

    int         cyc;
    int         n_vec;
    int         n_err;
    bit         echo_en;
    logic [3:0] ack_mask;
    out_t       prev;
    ev_t        exp_q[$];
    ev_t        obs_q[$];

    always #5 clk_in = ~clk_in;

    rst_seq_ctrl #(
        .NUM_STAGES (4),
        .STAGE_DELAY(4),
        .ACK_TIMEOUT(32),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk_in     (clk_in),
        .sys_reset_n(sys_reset_n),
        .sw_rst_req (sw_rst_req),
        .stage_ack  (stage_ack),
        .stage_rst_n(stage_rst_n),
        .seq_done   (seq_done),
        .timeout_err(timeout_err),
        .err_stage  (err_stage),
        .lost_ack   (lost_ack)
    );

    function automatic out_t snap();
        out_t s;
        s.rst  = stage_rst_n;
        s.done = seq_done;
        s.terr = timeout_err;
        s.est  = err_stage;
        s.lost = lost_ack;
        return s;
    endfunction

    function automatic ev_t mk(int c, logic [3:0] r, logic d, logic t, logic [1:0] s, logic l);
        ev_t e;
        e.cyc    = c;
        e.o.rst  = r;
        e.o.done = d;
        e.o.terr = t;
        e.o.est  = s;
        e.o.lost = l;
        return e;
    endfunction

    // Steps n clock edges; acks echo stage_rst_n (masked) one cycle later; records output changes.
    task automatic advance(input int n);
        out_t cur;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (echo_en) stage_ack = stage_rst_n & ack_mask;
            cur = snap();
            if (cur !== prev) obs_q.push_back('{cyc: cyc, o: cur});
            prev = cur;
        end
    endtask

    // Called 1 time unit after an edge; the next edge is edge 1 sampling reset high.
    task automatic release_rst();
        sys_reset_n = 1'b0;
        #3;
        sys_reset_n = 1'b1;
        cyc = 0;
        obs_q.delete();
        prev = snap();
    endtask

    task automatic test_reset();
        out_t z;
        z = '0;
        #2;
        sys_reset_n = 1'b0;
        stage_ack   = 4'b1111;
        #2;
        n_vec++;
        if (snap() !== z) begin
            n_err++;
            $display("FAIL reset_async: got %p, required %p", snap(), z);
        end
        repeat (3) @(posedge clk_in);
        #1;
        n_vec++;
        if (snap() !== z) begin
            n_err++;
            $display("FAIL reset_hold: got %p, required %p", snap(), z);
        end
    endtask

    task automatic test_sequence();
        ev_t e, o;
        ack_mask = 4'b1111;
        exp_q.push_back(mk(6,  4'b0001, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(11, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(16, 4'b0111, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(21, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(22, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0));
        release_rst();
        advance(40);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL seq_event: got none, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL seq_event: got %p, required %p", o, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL seq_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_lost_ack();
        ev_t e, o;
        echo_en   = 1'b0;
        stage_ack = 4'b0111;
        cyc       = 0;
        obs_q.delete();
        prev = snap();
        if (MON) exp_q.push_back(mk(1, 4'b1111, 1'b1, 1'b0, 2'd3, 1'b1));
        advance(1);
        stage_ack = 4'b1111;
        advance(4);
        echo_en = 1'b1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL lost_event: got none, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL lost_event: got %p, required %p", o, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL lost_extra: got %0d extra events, required 0", obs_q.size());
        end
        n_vec++;
        if (lost_ack !== MON) begin
            n_err++;
            $display("FAIL lost_flag: got %b, required %b", lost_ack, MON);
        end
    endtask

    task automatic test_timeout();
        ev_t e, o;
        ack_mask = 4'b1011;
        exp_q.push_back(mk(6,  4'b0001, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(11, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(16, 4'b0111, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(48, 4'b0111, 1'b0, 1'b1, 2'd2, 1'b0));
        release_rst();
        advance(248);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL tmo_event: got none, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL tmo_event: got %p, required %p", o, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL tmo_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_sw_restart();
        ev_t e, o;
        ack_mask = 4'b1111;
        exp_q.push_back(mk(1,  4'b0000, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(5,  4'b0001, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(10, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(15, 4'b0111, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(20, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(21, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0));
        cyc = 0;
        obs_q.delete();
        prev       = snap();
        sw_rst_req = 1'b1;
        advance(1);
        sw_rst_req = 1'b0;
        advance(25);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL sw_event: got none, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL sw_event: got %p, required %p", o, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL sw_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_async_reset();
        ev_t  e, o;
        out_t z;
        z = '0;
        // Restart from DONE, then drop sys_reset_n between edges inside stage 1's gap.
        exp_q.push_back(mk(1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(5, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc = 0;
        obs_q.delete();
        prev       = snap();
        sw_rst_req = 1'b1;
        advance(1);
        sw_rst_req = 1'b0;
        advance(7);
        #3;
        sys_reset_n = 1'b0;
        #1;
        n_vec++;
        if (snap() !== z) begin
            n_err++;
            $display("FAIL async_zero: got %p, required %p", snap(), z);
        end
        #2;
        sys_reset_n = 1'b1;
        exp_q.push_back(mk(6,  4'b0001, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(11, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(16, 4'b0111, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(21, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(22, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0));
        cyc  = 0;
        prev = snap();
        advance(25);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL async_event: got none, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL async_event: got %p, required %p", o, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL async_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_ack_boundary();
        ev_t e, o;
        // Stage 1 released at edge 11; its ack first sampled at edge 43, the 32nd wait cycle.
        ack_mask = 4'b1101;
        exp_q.push_back(mk(6,  4'b0001, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(11, 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(47, 4'b0111, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(52, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(mk(53, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0));
        release_rst();
        for (int k = 0; k < 60; k++) begin
            advance(1);
            if (cyc == 42) begin
                ack_mask  = 4'b1111;
                stage_ack = stage_rst_n & ack_mask;
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL edge_event: got none, required %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL edge_event: got %p, required %p", o, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL edge_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        echo_en  = 1'b1;
        ack_mask = 4'b1111;
        prev     = '0;
        test_reset();
        test_sequence();
        test_lost_ack();
        test_timeout();
        test_sw_restart();
        test_async_reset();
        test_ack_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
